// File: rtl/rf_dbg_pkg.sv
// Shared types for the register-file debug controller: FSM state encoding
// and the default writeback drain length.
package rf_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_ACCESS,
      ST_RESP
   } state_e;

   localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/rf_port_mux.sv
// Core/debug selector for the register-file input buses. Read port 2 always
// belongs to the core; the other ports switch to the debug side during ACCESS.
module rf_port_mux #(
   parameter int p_WORD_LEN     = 16,
   parameter int p_REG_ADDR_LEN = 3
) (
   input  logic                      sel_dbg,
   input  logic [p_REG_ADDR_LEN-1:0] core_src1,
   input  logic [p_REG_ADDR_LEN-1:0] core_src2,
   input  logic [p_REG_ADDR_LEN-1:0] core_tgt,
   input  logic [p_WORD_LEN-1:0]     core_tgt_data,
   input  logic                      core_wr_en,
   input  logic                      dbg_valid,
   input  logic                      dbg_we,
   input  logic [p_REG_ADDR_LEN-1:0] dbg_addr,
   input  logic [p_WORD_LEN-1:0]     dbg_wdata,
   output logic [p_REG_ADDR_LEN-1:0] rf_src1,
   output logic [p_REG_ADDR_LEN-1:0] rf_src2,
   output logic [p_REG_ADDR_LEN-1:0] rf_tgt,
   output logic [p_WORD_LEN-1:0]     rf_tgt_data,
   output logic                      rf_wr_en
);

   // Debug side wins outright: a core write arriving in ACCESS is dropped here.
   always_comb begin
      rf_src2 = core_src2;
      if (sel_dbg) begin
         rf_src1     = dbg_addr;
         rf_tgt      = dbg_addr;
         rf_tgt_data = dbg_wdata;
         rf_wr_en    = dbg_valid & dbg_we;
      end else begin
         rf_src1     = core_src1;
         rf_tgt      = core_tgt;
         rf_tgt_data = core_tgt_data;
         rf_wr_en    = core_wr_en;
      end
   end

endmodule

// File: rtl/regfile_dbg_ctrl.sv
// Arbitrates the register file between the core pipeline and a debug port:
// stall, drain in-flight writebacks, then perform one debug read or write.
module regfile_dbg_ctrl
   import rf_dbg_pkg::*;
#(
   parameter int p_WORD_LEN     = 16,
   parameter int p_REG_ADDR_LEN = 3,
   parameter int p_DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [p_REG_ADDR_LEN-1:0] i_core_src1,
   input  logic [p_REG_ADDR_LEN-1:0] i_core_src2,
   input  logic [p_REG_ADDR_LEN-1:0] i_core_tgt,
   input  logic [p_WORD_LEN-1:0]     i_core_tgt_data,
   input  logic                      i_core_wr_en,
   output logic                      o_stall,
   output logic [p_REG_ADDR_LEN-1:0] o_rf_src1,
   output logic [p_REG_ADDR_LEN-1:0] o_rf_src2,
   output logic [p_REG_ADDR_LEN-1:0] o_rf_tgt,
   output logic [p_WORD_LEN-1:0]     o_rf_tgt_data,
   output logic                      o_rf_wr_en,
   input  logic [p_WORD_LEN-1:0]     i_rf_src1_data,
   input  logic                      i_dbg_valid,
   input  logic                      i_dbg_we,
   input  logic [p_REG_ADDR_LEN-1:0] i_dbg_addr,
   input  logic [p_WORD_LEN-1:0]     i_dbg_wdata,
   output logic                      o_dbg_ready,
   output logic [p_WORD_LEN-1:0]     o_dbg_rdata,
   output logic                      o_dbg_rvalid,
   output logic                      o_collision
);

   localparam int CNT_W = $clog2(p_DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(p_DRAIN_CYCLES);

   state_e           state;
   state_e           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             rd_flag;

   // Handshake: a request transfers in the cycle where i_dbg_valid and
   // o_dbg_ready are both high; the requester holds we/addr/wdata stable
   // from valid rising until that cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (i_dbg_valid) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (!i_dbg_valid)        state_nxt = ST_IDLE;
            else if (cnt == CNT_ONE) state_nxt = ST_ACCESS;
         end
         ST_ACCESS: state_nxt = i_dbg_valid ? ST_RESP : ST_IDLE;
         ST_RESP:   state_nxt = i_dbg_valid ? ST_ACCESS : ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      o_stall      = (state != ST_IDLE);
      o_dbg_ready  = (state == ST_ACCESS);
      o_dbg_rvalid = (state == ST_RESP) && rd_flag;
   end

   // The counter loads only on entry to DRAIN, so it never wraps.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt         <= '0;
         rd_flag     <= 1'b0;
         o_dbg_rdata <= '0;
         o_collision <= 1'b0;
      end else begin
         if (state == ST_IDLE && i_dbg_valid)
            cnt <= CNT_LOAD;
         else if (state == ST_DRAIN && cnt != '0)
            cnt <= cnt - CNT_ONE;
         if (state == ST_ACCESS && i_dbg_valid) begin
            rd_flag <= ~i_dbg_we;
            if (!i_dbg_we) o_dbg_rdata <= i_rf_src1_data;
         end
         if (state == ST_ACCESS && i_core_wr_en)
            o_collision <= 1'b1;
      end
   end

   rf_port_mux #(
      .p_WORD_LEN     (p_WORD_LEN),
      .p_REG_ADDR_LEN (p_REG_ADDR_LEN)
   ) u_mux (
      .sel_dbg       (state == ST_ACCESS),
      .core_src1     (i_core_src1),
      .core_src2     (i_core_src2),
      .core_tgt      (i_core_tgt),
      .core_tgt_data (i_core_tgt_data),
      .core_wr_en    (i_core_wr_en),
      .dbg_valid     (i_dbg_valid),
      .dbg_we        (i_dbg_we),
      .dbg_addr      (i_dbg_addr),
      .dbg_wdata     (i_dbg_wdata),
      .rf_src1       (o_rf_src1),
      .rf_src2       (o_rf_src2),
      .rf_tgt        (o_rf_tgt),
      .rf_tgt_data   (o_rf_tgt_data),
      .rf_wr_en      (o_rf_wr_en)
   );

endmodule

// File: tb/tb_regfile_dbg_ctrl.sv
// Bench for regfile_dbg_ctrl: a per-cycle timeline model of the expected
// outputs, an 8x16 register file behind the muxed ports, and directed scenarios.
module tb_regfile_dbg_ctrl;

   localparam int W    = 16;
   localparam int A    = 3;
   localparam int D    = 3;
   localparam int MAXC = 512;

   logic         clk = 1'b0;
   logic         rst;
   logic [A-1:0] i_core_src1, i_core_src2, i_core_tgt;
   logic [W-1:0] i_core_tgt_data;
   logic         i_core_wr_en;
   logic         o_stall;
   logic [A-1:0] o_rf_src1, o_rf_src2, o_rf_tgt;
   logic [W-1:0] o_rf_tgt_data;
   logic         o_rf_wr_en;
   logic [W-1:0] i_rf_src1_data;
   logic         i_dbg_valid, i_dbg_we;
   logic [A-1:0] i_dbg_addr;
   logic [W-1:0] i_dbg_wdata;
   logic         o_dbg_ready;
   logic [W-1:0] o_dbg_rdata;
   logic         o_dbg_rvalid;
   logic         o_collision;

   // ---------------- clock / reset / cycle counter ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   regfile_dbg_ctrl #(
      .p_WORD_LEN     (W),
      .p_REG_ADDR_LEN (A),
      .p_DRAIN_CYCLES (D)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_core_src1     (i_core_src1),
      .i_core_src2     (i_core_src2),
      .i_core_tgt      (i_core_tgt),
      .i_core_tgt_data (i_core_tgt_data),
      .i_core_wr_en    (i_core_wr_en),
      .o_stall         (o_stall),
      .o_rf_src1       (o_rf_src1),
      .o_rf_src2       (o_rf_src2),
      .o_rf_tgt        (o_rf_tgt),
      .o_rf_tgt_data   (o_rf_tgt_data),
      .o_rf_wr_en      (o_rf_wr_en),
      .i_rf_src1_data  (i_rf_src1_data),
      .i_dbg_valid     (i_dbg_valid),
      .i_dbg_we        (i_dbg_we),
      .i_dbg_addr      (i_dbg_addr),
      .i_dbg_wdata     (i_dbg_wdata),
      .o_dbg_ready     (o_dbg_ready),
      .o_dbg_rdata     (o_dbg_rdata),
      .o_dbg_rvalid    (o_dbg_rvalid),
      .o_collision     (o_collision)
   );

   // Register file behind the controller; r0 is hard-wired to zero.
   logic [W-1:0] rf [8];
   always @(posedge clk)
      if (o_rf_wr_en && o_rf_tgt != '0) rf[o_rf_tgt] <= o_rf_tgt_data;
   assign i_rf_src1_data = (o_rf_src1 == '0) ? '0 : rf[o_rf_src1];

   // ---------------- expectation timeline (model) ----------------
   logic [W-1:0] model_rf [8];
   logic         exp_stall [MAXC];
   logic         exp_ready [MAXC];
   logic         exp_rvalid[MAXC];
   logic         exp_sel   [MAXC];
   logic         exp_coll  [MAXC];
   logic [W-1:0] exp_rdata [MAXC];
   int           ready_q[$];
   int           rvalid_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
      end
   endtask

   task automatic clear_from(input int c);
      for (int k = c; k < MAXC; k++) begin
         exp_stall[k] = 1'b0; exp_ready[k] = 1'b0; exp_rvalid[k] = 1'b0;
         exp_sel[k] = 1'b0; exp_coll[k] = 1'b0; exp_rdata[k] = '0;
      end
   endtask

   task automatic rdata_from(input int c, input logic [W-1:0] v);
      for (int k = c; k < MAXC; k++) exp_rdata[k] = v;
   endtask

   task automatic coll_from(input int c);
      for (int k = c; k < MAXC; k++) exp_coll[k] = 1'b1;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cyc < MAXC) begin
         check("stall",  32'(o_stall),      32'(exp_stall[cyc]));
         check("ready",  32'(o_dbg_ready),  32'(exp_ready[cyc]));
         check("rvalid", 32'(o_dbg_rvalid), 32'(exp_rvalid[cyc]));
         check("rdata",  32'(o_dbg_rdata),  32'(exp_rdata[cyc]));
         check("coll",   32'(o_collision),  32'(exp_coll[cyc]));
         check("src2",   32'(o_rf_src2),    32'(i_core_src2));
         if (exp_sel[cyc]) begin
            check("dbg_src1", 32'(o_rf_src1),     32'(i_dbg_addr));
            check("dbg_tgt",  32'(o_rf_tgt),      32'(i_dbg_addr));
            check("dbg_wd",   32'(o_rf_tgt_data), 32'(i_dbg_wdata));
            check("dbg_we",   32'(o_rf_wr_en),    32'(i_dbg_valid & i_dbg_we));
         end else begin
            check("core_src1", 32'(o_rf_src1),     32'(i_core_src1));
            check("core_tgt",  32'(o_rf_tgt),      32'(i_core_tgt));
            check("core_wd",   32'(o_rf_tgt_data), 32'(i_core_tgt_data));
            check("core_we",   32'(o_rf_wr_en),    32'(i_core_wr_en));
         end
         if (o_dbg_ready)  ready_q.push_back(cyc);
         if (o_dbg_rvalid) rvalid_q.push_back(cyc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         i_core_src1 = A'($urandom_range(0, 7));
         i_core_src2 = A'($urandom_range(0, 7));
         tick();
      end
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      clear_from(cyc);
      i_dbg_valid  = 1'b0;
      i_core_wr_en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic core_write(input logic [A-1:0] a, input logic [W-1:0] d);
      i_core_tgt = a; i_core_tgt_data = d; i_core_wr_en = 1'b1;
      if (a != '0) model_rf[a] = d;
      tick();
      i_core_wr_en = 1'b0;
   endtask

   // One debug transfer. first: raise valid from IDLE (drain applies);
   // otherwise called in the RESP cycle of the previous transfer.
   // last: drop valid in RESP. collide: core writes cdata to the same address in ACCESS.
   task automatic dbg_access(input logic we, input logic [A-1:0] a, input logic [W-1:0] d,
                             input bit first, input bit last, input bit collide,
                             input logic [W-1:0] cdata);
      int acc;
      i_dbg_we = we; i_dbg_addr = a; i_dbg_wdata = d;
      if (first) begin
         i_dbg_valid = 1'b1;
         acc = cyc + D + 1;
         for (int k = cyc + 1; k < acc; k++) exp_stall[k] = 1'b1;
      end else begin
         acc = cyc + 1;
      end
      exp_stall[acc] = 1'b1; exp_stall[acc+1] = 1'b1;
      exp_ready[acc] = 1'b1; exp_sel[acc] = 1'b1;
      exp_rvalid[acc+1] = ~we;
      if (we) begin
         if (a != '0) model_rf[a] = d;
      end else begin
         rdata_from(acc + 1, (a == '0) ? '0 : model_rf[a]);
      end
      if (collide) coll_from(acc + 1);
      while (cyc < acc) tick();
      if (collide) begin
         i_core_tgt = a; i_core_tgt_data = cdata; i_core_wr_en = 1'b1;
      end
      tick();
      i_core_wr_en = 1'b0;
      if (last) begin
         i_dbg_valid = 1'b0;
         tick();
      end
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (q.size() > i) ? q[i] : -1;
   endfunction

   // ---------------- scenarios ----------------
   initial begin
      int n0;
      #100000;
      $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      for (int i = 0; i < 8; i++) begin
         rf[i]       = (i == 0) ? '0 : W'(16'h1000 + i);
         model_rf[i] = (i == 0) ? '0 : W'(16'h1000 + i);
      end
      clear_from(0);
      rst = 1'b1;
      i_core_src1 = '0; i_core_src2 = '0; i_core_tgt = '0;
      i_core_tgt_data = '0; i_core_wr_en = 1'b0;
      i_dbg_valid = 1'b0; i_dbg_we = 1'b0; i_dbg_addr = '0; i_dbg_wdata = '0;
      apply_reset();
      check("rst_stall", 32'(o_stall), 32'd0);
      check("rst_rdata", 32'(o_dbg_rdata), 32'd0);
      check("rst_coll",  32'(o_collision), 32'd0);
      idle(2);

      // Read r3 after a core write
      core_write(3'd3, 16'h1234);
      idle(1);
      ready_q.delete(); rvalid_q.delete();
      n0 = cyc;
      dbg_access(1'b0, 3'd3, '0, 1, 1, 0, '0);
      check("rd_ready_cyc",  32'(q_at(ready_q, 0)),  32'(n0 + 4));
      check("rd_rvalid_cyc", 32'(q_at(rvalid_q, 0)), 32'(n0 + 5));
      check("rd_r3_data",    32'(o_dbg_rdata), 32'h1234);
      idle(2);

      // Write r5, then the core reads it back
      dbg_access(1'b1, 3'd5, 16'hBEEF, 1, 1, 0, '0);
      idle(1);
      i_core_src1 = 3'd5;
      #1;
      check("core_rd_r5", 32'(i_rf_src1_data), 32'hBEEF);
      idle(2);

      // Write to r0 is swallowed; read of r0 returns zero
      ready_q.delete();
      dbg_access(1'b1, 3'd0, 16'hFFFF, 1, 1, 0, '0);
      check("r0_wr_handshake", 32'(ready_q.size()), 32'd1);
      idle(1);
      dbg_access(1'b0, 3'd0, '0, 1, 1, 0, '0);
      check("r0_rd_data", 32'(o_dbg_rdata), 32'h0000);
      idle(2);

      // Abort: valid dropped in the second DRAIN cycle
      ready_q.delete();
      n0 = cyc;
      i_dbg_we = 1'b1; i_dbg_addr = 3'd6; i_dbg_wdata = 16'h7777; i_dbg_valid = 1'b1;
      exp_stall[n0+1] = 1'b1; exp_stall[n0+2] = 1'b1;
      tick(); tick();
      i_dbg_valid = 1'b0;
      tick();
      check("abort_stall_c3", 32'(o_stall), 32'd0);
      idle(4);
      check("abort_no_ready", 32'(ready_q.size()), 32'd0);

      // Back-to-back: write r1 then read r1 with valid held
      ready_q.delete(); rvalid_q.delete();
      n0 = cyc;
      dbg_access(1'b1, 3'd1, 16'h0001, 1, 0, 0, '0);
      dbg_access(1'b0, 3'd1, '0, 0, 1, 0, '0);
      check("b2b_ready0", 32'(q_at(ready_q, 0)), 32'(n0 + 4));
      check("b2b_gap",    32'(q_at(ready_q, 1) - q_at(ready_q, 0)), 32'd2);
      check("b2b_rdata",  32'(o_dbg_rdata), 32'h0001);
      idle(2);

      // Reset asserted during DRAIN
      n0 = cyc;
      i_dbg_we = 1'b1; i_dbg_addr = 3'd4; i_dbg_wdata = 16'hDEAD; i_dbg_valid = 1'b1;
      exp_stall[n0+1] = 1'b1; exp_stall[n0+2] = 1'b1;
      tick(); tick();
      apply_reset();
      check("rst_mid_stall", 32'(o_stall), 32'd0);
      check("rst_mid_rdata", 32'(o_dbg_rdata), 32'd0);
      check("rst_mid_r4",    32'(rf[4]), 32'h1004);
      idle(2);

      // Collision: core writes r2 during debug ACCESS of r2
      dbg_access(1'b1, 3'd2, 16'h5555, 1, 1, 1, 16'hAAAA);
      idle(3);
      check("coll_sticky", 32'(o_collision), 32'd1);
      check("coll_r2",     32'(rf[2]), 32'h5555);
      apply_reset();
      check("coll_cleared", 32'(o_collision), 32'd0);
      idle(2);

      for (int i = 0; i < 8; i++) check($sformatf("rf_final_r%0d", i), 32'(rf[i]), 32'(model_rf[i]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
